// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU engine producing Hi/Lo write data over 34 cycles
module muldiv_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [31:0] b_q, b_d, rs_q, rs_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d;
  logic sq_q, sq_d, sr_q, sr_d, busy_q, busy_d, done_q, done_d;
  logic [31:0] rs_mag, rt_mag, quo, rmd;
  logic [32:0] sum, rem, diff;
  logic [63:0] prod;
  logic is_div, signed_op;
  always_comb begin
    is_div = op_q[1];
    signed_op = !op_q[0];
    rs_mag = (!op[0] && rs_val[31]) ? -rs_val : rs_val;
    rt_mag = (!op[0] && rt_val[31]) ? -rt_val : rt_val;
    sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem = {acc_q[63:31]};
    diff = rem - {1'b0, b_q};
    prod = (signed_op && sq_q) ? -acc_q : acc_q;
    quo = (signed_op && sq_q) ? -acc_q[31:0] : acc_q[31:0];
    rmd = (signed_op && sr_q) ? -acc_q[63:32] : acc_q[63:32];
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    b_d = b_q;
    rs_d = rs_q;
    hi_d = hi_q;
    lo_d = lo_q;
    acc_d = acc_q;
    sq_d = sq_q;
    sr_d = sr_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = CALC;
        cnt_d = 6'd0;
        op_d = op;
        busy_d = 1'b1;
        rs_d = rs_val;
        sq_d = rs_val[31] ^ rt_val[31];
        sr_d = rs_val[31];
        b_d = op[1] ? rt_mag : rs_mag;
        acc_d = {32'd0, op[1] ? rs_mag : rt_mag};
      end
      CALC: if (abort) begin
        state_d = IDLE;
        busy_d = 1'b0;
      end else begin
        acc_d = is_div ? {diff[32] ? rem[31:0] : diff[31:0], acc_q[30:0], !diff[32]} : {sum, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd31) ? FIX : CALC;
      end
      FIX: if (abort) begin
        state_d = IDLE;
        busy_d = 1'b0;
      end else begin
        state_d = DONE;
        done_d = 1'b1;
        hi_d = !is_div ? prod[63:32] : (b_q == 32'd0) ? rs_q : rmd;
        lo_d = !is_div ? prod[31:0] : (b_q == 32'd0) ? 32'hFFFF_FFFF : quo;
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= 6'd0;
      op_q <= 2'd0;
      b_q <= 32'd0;
      rs_q <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      acc_q <= 64'd0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      b_q <= b_d;
      rs_q <= rs_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      acc_q <= acc_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign hi_we = done_q;
  assign lo_we = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide engine that produces the Hi/Lo results consumed by the Hi and Lo registers in the MIPS datapath. It accepts MULT, MULTU, DIV and DIVU operands from the EX stage. It computes the result over a fixed 34-cycle sequence, then drives the Hi/Lo write data and write enables for exactly one cycle. `busy` lets the hazard unit stall MFHI/MFLO and any new mult/div until the result is written.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin an operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32  multiplicand / dividend.
- `rt_val`  in  32  multiplier / divisor.
- `abort`  in  1  synchronous cancel (pipeline flush); no Hi/Lo write results.
- `busy`  out  1  high from accept edge until return to IDLE.
- `done`  out  1  one-cycle pulse; `hi_out`/`lo_out` valid.
- `hi_we`  out  1  Hi register enable; equals `done`.
- `lo_we`  out  1  Lo register enable; equals `done`.
- `hi_out`  out  32  product[63:32] or remainder.
- `lo_out`  out  32  product[31:0] or quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: when `start`=1 and `abort`=0, latch `op`, |rs|, |rt| and the result sign flags, clear the 6-bit iteration counter, then go to CALC.
  - For unsigned ops, the magnitudes are the raw operands.
- CALC: one iteration per cycle, 32 iterations, counter 0..31; go to FIX after iteration 31.
  - Multiply: shift-add over a 64-bit accumulator, unsigned on magnitudes.
  - Divide: restoring division, one quotient bit per cycle, using a 33-bit partial-remainder subtract.
- FIX: apply signs and register `hi_out`/`lo_out`, then go to DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend is negative. This gives truncation toward zero, with the remainder sign following the dividend.
- DONE: `done`=`hi_we`=`lo_we`=1 for exactly one cycle, then go to IDLE.
- Divide by zero (DIV or DIVU with `rt_val`=0): `lo_out`=0xFFFFFFFF and `hi_out`=`rs_val`. Latency is the same as a normal operation.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): `lo_out`=0x80000000, `hi_out`=0. Results wrap modulo 2^32 and no exception is raised.
- `abort`=1 in CALC or FIX: go to IDLE on the next edge. `done`/`hi_we`/`lo_we` never assert, and `hi_out`/`lo_out` keep their previous values.
- `abort`=1 in DONE: the write still occurs, because the result is committed once FIX completes.
- `start` while busy (CALC, FIX or DONE): ignored. The hazard unit must hold the request until `busy`=0.
- Simultaneous `start` and `abort` in IDLE: abort wins and nothing is accepted.
- All register, sign and arithmetic operations are 32-bit. The product is 64 bits, and all negation is two's complement.

## Timing
- Reset (`reset_n`=0, asynchronous): state=IDLE and counter=0. `busy`=`done`=`hi_we`=`lo_we`=0 and `hi_out`=`lo_out`=0. This holds from assertion with no clock needed.
- Reset asserted mid-operation discards the operation; no write occurs.
- Let the accept edge be N:
  - `busy`=1 after edge N.
  - CALC covers edges N+1..N+32.
  - FIX registers results at edge N+33.
  - `done`/`hi_we`/`lo_we`=1 during the cycle between N+33 and N+34.
  - `busy`=0 after N+34.
- The next `start` can be accepted at edge N+34 or later. Back-to-back throughput is one operation per 34 cycles.
- The Hi/Lo registers capture the result at edge N+34, so MFHI/MFLO may read at or after N+34.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi_out`=0xFFFFFFFE, `lo_out`=0x00000001. `done` pulses exactly once, in the cycle after edge N+33.
- MULT 0xFFFFFFFD (−3) × 0x00000005 → `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 → `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF.
- DIVU 100 / 7 → `lo_out`=0x0000000E, `hi_out`=0x00000002.
- DIVU 0x12345678 / 0 → `lo_out`=0xFFFFFFFF, `hi_out`=0x12345678. Also run DIV 0x80000000 / 0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0.
- Start a MULT, pulse `abort` at edge N+10 → IDLE at N+11, no `hi_we`; then pulse `start` during busy → ignored. Separately, assert `reset_n`=0 at N+20 → all outputs 0 immediately.
